// File: rtl/snake_seg_decoder.sv
// Receive-side monitor for the two-digit seven-segment snake animation.
// Optional reverse stepping is enabled by defining SNAKE_DEC_REVERSE_EN.
module snake_seg_decoder #(
  parameter int unsigned LAP_W    = 8,
  parameter int unsigned LOCK_CNT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a1,
  input  logic             a2,
  input  logic             b1,
  input  logic             b2,
  input  logic             c1,
  input  logic             c2,
  input  logic             d1,
  input  logic             d2,
  input  logic             e1,
  input  logic             e2,
  input  logic             f1,
  input  logic             f2,
  input  logic             g1,
  input  logic             g2,
  input  logic             err_clr,
  output logic [3:0]       pos,
  output logic             valid,
  output logic             locked,
  output logic             step,
  output logic             dir,
  output logic             err,
  output logic [LAP_W-1:0] lap_cnt
);

  typedef enum logic [1:0] {SEARCH, LOCKING, LOCKED} state_t;

  state_t           state, state_nxt;
  logic [13:0]      seg_q, seg_prev;
  logic [3:0]       idx, cnt, cnt_nxt, cnt_inc, pos_nxt, next_pos;
  logic             legal, change, is_fwd;
  logic             valid_nxt, locked_nxt, step_nxt, dir_nxt, err_nxt, err_set;
  logic [LAP_W-1:0] lap_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg_q    <= '0;
      seg_prev <= '0;
    end else begin
      seg_q    <= {a1, a2, b1, b2, c1, c2, d1, d2, e1, e2, f1, f2, g1, g2};
      seg_prev <= seg_q;
    end
  end

  always_comb begin
    legal = 1'b1;
    idx   = '0;
    case (seg_q)
      14'h3400: idx = 4'd0;
      14'h1401: idx = 4'd1;
      14'h0403: idx = 4'd2;
      14'h0023: idx = 4'd3;
      14'h00A2: idx = 4'd4;
      14'h00E0: idx = 4'd5;
      14'h01C0: idx = 4'd6;
      14'h0141: idx = 4'd7;
      14'h0103: idx = 4'd8;
      14'h000B: idx = 4'd9;
      14'h200A: idx = 4'd10;
      14'h3008: idx = 4'd11;
      default:  legal = 1'b0;
    endcase
  end

  assign change   = (seg_q != seg_prev);
  assign next_pos = (pos == 4'd11) ? 4'd0 : pos + 4'd1;
  assign is_fwd   = legal && (idx == next_pos);
  assign cnt_inc  = cnt + 4'd1;

`ifdef SNAKE_DEC_REVERSE_EN
  logic [3:0] prev_pos;
  logic       is_rev;
  assign prev_pos = (pos == 4'd0) ? 4'd11 : pos - 4'd1;
  assign is_rev   = legal && (idx == prev_pos);
`endif

  always_comb begin
    state_nxt  = state;
    pos_nxt    = pos;
    valid_nxt  = valid;
    locked_nxt = locked;
    step_nxt   = 1'b0;
    dir_nxt    = dir;
    lap_nxt    = lap_cnt;
    cnt_nxt    = cnt;
    err_set    = 1'b0;
    if (change) begin
      case (state)
        SEARCH: begin
          if (legal) begin
            pos_nxt   = idx;
            valid_nxt = 1'b1;
            cnt_nxt   = '0;
            state_nxt = LOCKING;
          end else begin
            valid_nxt = 1'b0;
          end
        end
        LOCKING: begin
          if (!legal) begin
            valid_nxt = 1'b0;
            state_nxt = SEARCH;
          end else if (is_fwd) begin
            pos_nxt = next_pos;
            cnt_nxt = cnt_inc;
            if (cnt_inc == 4'(LOCK_CNT)) begin
              locked_nxt = 1'b1;
              state_nxt  = LOCKED;
            end
          end else begin
            pos_nxt = idx;
            cnt_nxt = '0;
          end
        end
        LOCKED: begin
          if (!legal) begin
            err_set    = 1'b1;
            locked_nxt = 1'b0;
            valid_nxt  = 1'b0;
            state_nxt  = SEARCH;
          end else if (is_fwd) begin
            pos_nxt  = next_pos;
            step_nxt = 1'b1;
            dir_nxt  = 1'b0;
            if (pos == 4'd11) lap_nxt = lap_cnt + LAP_W'(1);
`ifdef SNAKE_DEC_REVERSE_EN
          end else if (is_rev) begin
            pos_nxt  = prev_pos;
            step_nxt = 1'b1;
            dir_nxt  = 1'b1;
            if (pos == 4'd0) lap_nxt = lap_cnt - LAP_W'(1);
`endif
          end else begin
            err_set    = 1'b1;
            locked_nxt = 1'b0;
            pos_nxt    = idx;
            cnt_nxt    = '0;
            state_nxt  = LOCKING;
          end
        end
        default: state_nxt = SEARCH;
      endcase
    end
  end

  // A new error wins over a same-cycle clear request.
  assign err_nxt = err_set | (err & ~err_clr);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= SEARCH;
      pos     <= '0;
      valid   <= 1'b0;
      locked  <= 1'b0;
      step    <= 1'b0;
      dir     <= 1'b0;
      err     <= 1'b0;
      lap_cnt <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_nxt;
      pos     <= pos_nxt;
      valid   <= valid_nxt;
      locked  <= locked_nxt;
      step    <= step_nxt;
      dir     <= dir_nxt;
      err     <= err_nxt;
      lap_cnt <= lap_nxt;
      cnt     <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_snake_seg_decoder.sv
// Table-driven bench for snake_seg_decoder; rows hold the pattern driven
// before an edge and the outputs expected just after that edge.
module tb_snake_seg_decoder;

  localparam logic [13:0] PAT [12] = '{
    14'h3400, 14'h1401, 14'h0403, 14'h0023, 14'h00A2, 14'h00E0,
    14'h01C0, 14'h0141, 14'h0103, 14'h000B, 14'h200A, 14'h3008};

  typedef struct {
    logic [13:0] pat;
    logic        clr;
    logic [3:0]  pos;
    logic        valid;
    logic        locked;
    logic        step;
    logic        dir;
    logic        err;
    logic [7:0]  lap;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] pat;
  logic        err_clr;
  logic        a1, a2, b1, b2, c1, c2, d1, d2, e1, e2, f1, f2, g1, g2;
  logic [3:0]  pos;
  logic        valid, locked, step, dir, err;
  logic [7:0]  lap_cnt;

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];

  assign {a1, a2, b1, b2, c1, c2, d1, d2, e1, e2, f1, f2, g1, g2} = pat;

  always #5 clk = ~clk;

  snake_seg_decoder #(.LAP_W(8), .LOCK_CNT(2)) dut (
    .clk(clk), .reset(reset),
    .a1(a1), .a2(a2), .b1(b1), .b2(b2), .c1(c1), .c2(c2), .d1(d1),
    .d2(d2), .e1(e1), .e2(e2), .f1(f1), .f2(f2), .g1(g1), .g2(g2),
    .err_clr(err_clr), .pos(pos), .valid(valid), .locked(locked),
    .step(step), .dir(dir), .err(err), .lap_cnt(lap_cnt));

  task automatic check(input string name, input int row, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  task automatic add(input logic [13:0] p, input logic c, input logic [3:0] ps,
                     input logic v, input logic l, input logic s, input logic d,
                     input logic e, input logic [7:0] lp);
    vec_t r;
    r.pat = p; r.clr = c; r.pos = ps; r.valid = v; r.locked = l;
    r.step = s; r.dir = d; r.err = e; r.lap = lp;
    tbl.push_back(r);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pos"},    0, 16'(pos), 16'd0);
    check({tag, "_valid"},  0, 16'(valid), 16'd0);
    check({tag, "_locked"}, 0, 16'(locked), 16'd0);
    check({tag, "_step"},   0, 16'(step), 16'd0);
    check({tag, "_dir"},    0, 16'(dir), 16'd0);
    check({tag, "_err"},    0, 16'(err), 16'd0);
    check({tag, "_lap"},    0, 16'(lap_cnt), 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev;
    int lap;
    int k;

    // Acquisition: outputs lag the driven pattern by one row.
    add(PAT[0], 0, 0, 0, 0, 0, 0, 0, 0);
    add(PAT[1], 0, 0, 1, 0, 0, 0, 0, 0);
    add(PAT[2], 0, 1, 1, 0, 0, 0, 0, 0);
    add(PAT[3], 0, 2, 1, 1, 0, 0, 0, 0);
    // Two laps plus a few positions, stepping every cycle.
    prev = 3; lap = 0;
    for (int n = 0; n < 26; n++) begin
      k = (4 + n) % 12;
      if (prev == 0) lap++;
      add(PAT[k], 0, 4'(prev), 1, 1, 1, 0, 0, 8'(lap));
      prev = k;
    end
    // Hold position 5: a single step only.
    add(PAT[5], 0, 5, 1, 1, 1, 0, 0, 8'(lap));
    for (int n = 0; n < 9; n++) add(PAT[5], 0, 5, 1, 1, 0, 0, 0, 8'(lap));
    // Advance to position 3, crossing one more lap boundary.
    add(PAT[6], 0, 5, 1, 1, 0, 0, 0, 8'(lap));
    prev = 6;
    for (int n = 0; n < 9; n++) begin
      k = (7 + n) % 12;
      if (prev == 0) lap++;
      add(PAT[k], 0, 4'(prev), 1, 1, 1, 0, 0, 8'(lap));
      prev = k;
    end
    // Skip 3->5, recover with err_clr, then illegal pattern and reacquire.
    add(PAT[5],   0, 3, 1, 1, 1, 0, 0, 3);
    add(PAT[6],   0, 5, 1, 0, 0, 0, 1, 3);
    add(PAT[7],   1, 6, 1, 0, 0, 0, 0, 3);
    add(14'h0000, 0, 7, 1, 1, 0, 0, 0, 3);
    add(14'h0000, 1, 7, 0, 0, 0, 0, 1, 3);
    add(14'h0000, 1, 7, 0, 0, 0, 0, 0, 3);
    add(PAT[9],   0, 7, 0, 0, 0, 0, 0, 3);
    add(PAT[10],  0, 9, 1, 0, 0, 0, 0, 3);
    add(PAT[11],  0, 10, 1, 0, 0, 0, 0, 3);
    add(PAT[0],   0, 11, 1, 1, 0, 0, 0, 3);
    add(PAT[1],   0, 0, 1, 1, 1, 0, 0, 4);
    add(PAT[0],   0, 1, 1, 1, 1, 0, 0, 4);
`ifdef SNAKE_DEC_REVERSE_EN
    add(PAT[0],   0, 0, 1, 1, 1, 1, 0, 4);
    add(PAT[11],  0, 0, 1, 1, 0, 1, 0, 4);
    add(PAT[11],  0, 11, 1, 1, 1, 1, 0, 3);
    add(PAT[11],  0, 11, 1, 1, 0, 1, 0, 3);
`else
    add(PAT[0],   0, 0, 1, 0, 0, 0, 1, 4);
    add(PAT[11],  0, 0, 1, 0, 0, 0, 1, 4);
    add(PAT[11],  0, 11, 1, 0, 0, 0, 1, 4);
    add(PAT[11],  0, 11, 1, 0, 0, 0, 1, 4);
`endif

    reset = 1'b0; pat = '0; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("rst");
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      pat = tbl[i].pat;
      err_clr = tbl[i].clr;
      @(posedge clk);
      #1;
      check("pos",    i, 16'(pos),     16'(tbl[i].pos));
      check("valid",  i, 16'(valid),   16'(tbl[i].valid));
      check("locked", i, 16'(locked),  16'(tbl[i].locked));
      check("step",   i, 16'(step),    16'(tbl[i].step));
      check("dir",    i, 16'(dir),     16'(tbl[i].dir));
      check("err",    i, 16'(err),     16'(tbl[i].err));
      check("lap",    i, 16'(lap_cnt), 16'(tbl[i].lap));
    end

    // Asynchronous reset between edges, then reacquire.
    @(negedge clk);
    pat = PAT[2]; err_clr = 1'b0;
    @(posedge clk);
    #1;
    check("pre_rst_valid", 0, 16'(valid), 16'd1);
    #1;
    reset = 1'b0;
    #1;
    check_all_zero("async");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("resume1_valid", 0, 16'(valid), 16'd0);
    @(posedge clk);
    #1;
    check("resume2_valid",  0, 16'(valid), 16'd1);
    check("resume2_pos",    0, 16'(pos), 16'd2);
    check("resume2_locked", 0, 16'(locked), 16'd0);
    check("resume2_err",    0, 16'(err), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/snake_seg_decoder.md
# snake_seg_decoder

Receive-side monitor for the two-digit seven-segment "snake" animation. It samples the 14 segment lines driven by the snake generator and decodes each pattern back to a position index 0–11. It checks that successive positions advance in ring order, counts completed laps, and flags protocol errors. It sits on the segment bus in parallel with the display, and is used for self-check on hardware and as the scoreboard in simulation.

## Interface
- `LAP_W`, default 8: width of the lap counter.
- `LOCK_CNT`, default 2: consecutive correct advances required to enter LOCKED (range 1–15).
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-low; all state is cleared while low.
- `a1,a2,b1,b2,c1,c2,d1,d2,e1,e2,f1,f2,g1,g2` in 1 each: segment lines, active-high.
- `err_clr` in 1: synchronous clear of `err`.
- `pos` out 4: last decoded position.
- `valid` out 1: `pos` holds a decoded (legal) pattern.
- `locked` out 1: tracker is in LOCKED.
- `step` out 1: one-cycle pulse on each accepted advance while LOCKED.
- `dir` out 1: direction of the last accepted step (0 = forward, 1 = reverse).
- `err` out 1: sticky sequence or pattern error.
- `lap_cnt` out LAP_W: count of completed laps, modulo 2^LAP_W.

## Operation
- Pattern vector P = {a1,a2,b1,b2,c1,c2,d1,d2,e1,e2,f1,f2,g1,g2}; bit 13 is a1 and bit 0 is g2.
- Legal patterns have exactly three lit segments:
  - 0={a1,a2,b2}=0x3400, 1={a2,b2,g2}=0x1401, 2={b2,g2,g1}=0x0403, 3={g2,g1,e1}=0x0023
  - 4={g1,e1,d1}=0x00A2, 5={e1,d1,d2}=0x00E0, 6={d1,d2,c2}=0x01C0, 7={d2,c2,g2}=0x0141
  - 8={c2,g2,g1}=0x0103, 9={g2,g1,f1}=0x000B, 10={g1,f1,a1}=0x200A, 11={f1,a1,a2}=0x3008
  - Every other value, including 0x0000, is illegal.
- Stage 1 registers P into `seg_q`. Stage 2 holds `seg_prev` (the previous `seg_q`), the decode of `seg_q`, and the FSM.
- A change is `seg_q != seg_prev`. When there is no change, the FSM holds and all outputs except `step` hold.
- Expected next position: E = (pos==11) ? 0 : pos+1.
- State SEARCH:
  - Legal change → load `pos`, set `valid`=1, clear the step count, go to LOCKING.
  - Illegal → `valid`=0, stay in SEARCH.
- State LOCKING:
  - Change to E → `pos`=E, increment the count. When the count reaches LOCK_CNT, go to LOCKED and set `locked`=1.
  - Change to any other legal pattern → reload `pos`, count=0.
  - Change to an illegal pattern → SEARCH, `valid`=0.
  - No error is raised in this state.
- State LOCKED:
  - Change to E → `pos`=E, pulse `step`, `dir`=0. On an 11→0 step, increment `lap_cnt` (wraps).
  - Change to another legal pattern → set `err`, clear `locked`, go to LOCKING with the new `pos`, count=0.
  - Change to an illegal pattern → set `err`, clear `locked` and `valid`, go to SEARCH.
- `err` priority: setting beats `err_clr` in the same cycle.

## Timing
- Reset values: `pos`=0, `valid`=0, `locked`=0, `step`=0, `dir`=0, `err`=0, `lap_cnt`=0, FSM=SEARCH, `seg_q`=`seg_prev`=0.
- Latency: a pattern present at edge k is decoded into the outputs at edge k+1. A sustained one-per-cycle stream gives one update per cycle.
- The first legal pattern after reset counts as a change, because `seg_prev` resets to 0x0000.
- `step` is high for exactly one cycle per accepted advance. A pattern held for N cycles produces one `step` at most.
- `err_clr` takes effect at the next edge. `err` reads 0 from the following cycle unless it is re-set.
- Reset asserted mid-operation clears everything immediately, without waiting for a clock. Operation resumes at the first edge after `reset` goes high.

## Configuration
- `SNAKE_DEC_REVERSE_EN` defined:
  - In LOCKED, a change to R = (pos==0) ? 11 : pos-1 is also accepted: `pos`=R, `step` pulses, `dir`=1.
  - A 0→11 reverse step decrements `lap_cnt` (wraps).
  - In LOCKING, R is treated as "other legal".
- `SNAKE_DEC_REVERSE_EN` undefined:
  - A reverse step in LOCKED is an error, as for any other legal mismatch.
  - `dir` is tied to 0.

## Test plan
- Acquisition: reset low then high; drive 0x3400, 0x1401, 0x0403 on successive cycles → `valid`=1 one cycle after 0x3400; `locked`=1 one cycle after 0x0403; `pos`=2; `err`=0.
- Laps: from locked at pos 2, stream positions 3…11,0 and then a full second lap → `lap_cnt`=2, `step` pulses every cycle, no `err`.
- Hold: while locked, hold 0x00E0 for 10 cycles → `pos`=5; only one `step` pulse; state unchanged.
- Skip: locked at pos 3 (0x0023), then drive 0x00E0 (pos 5) → `err`=1, `locked`=0, `pos`=5. Then assert `err_clr` with pos 6, 7 following → `err`=0 and `locked`=1 after 2 advances.
- Illegal pattern: locked, then drive 0x0000 → `err`=1, `valid`=0, SEARCH. With `err_clr` asserted the same cycle, `err` still reads 1.
- Async reset: assert `reset` low mid-lap between clock edges → all outputs read 0 before the next edge. With the macro defined, drive pos 0 then 0x3008 while locked → `dir`=1, `lap_cnt` decrements.
